// File: rtl/move_pkg.sv
// Shared definitions for the move unit: opcode encodings and the opcode type.
package move_pkg;

    localparam logic [1:0] MOV_OP_MOV = 2'b00;
    localparam logic [1:0] MOV_OP_MVN = 2'b01;
    localparam logic [1:0] MOV_OP_CLR = 2'b10;
    localparam logic [1:0] MOV_OP_SWP = 2'b11;

    typedef enum logic [1:0] {
        OP_MOV = MOV_OP_MOV,
        OP_MVN = MOV_OP_MVN,
        OP_CLR = MOV_OP_CLR,
        OP_SWP = MOV_OP_SWP
    } move_op_e;

endpackage

// File: rtl/move_op.sv
// Combinational move-class datapath: produces the result and its zero/negative flags.
module move_op
    import move_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg
);

    always_comb begin
        result = '0;
        unique case (op)
            MOV_OP_MOV: result = A;
            MOV_OP_MVN: result = ~A;
            MOV_OP_CLR: result = '0;
            MOV_OP_SWP: result = {A[WIDTH/2-1:0], A[WIDTH-1:WIDTH/2]};
            default:    result = '0;
        endcase
        zero = (result == '0);
        neg  = result[WIDTH-1];
    end

endmodule

// File: rtl/move_unit.sv
// Move unit: computes a move-class result and queues it, with flags, in a small
// DEPTH-entry buffer drained over a valid/ready handshake.
module move_unit
    import move_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           A,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           A_move,
    output logic                       zero,
    output logic                       neg,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             neg;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    move_op #(.WIDTH(WIDTH)) u_op (
        .op     (op),
        .A      (A),
        .result (new_entry.result),
        .zero   (new_entry.zero),
        .neg    (new_entry.neg)
    );

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    assign head   = mem[rd_ptr];
    assign A_move = out_valid ? head.result : '0;
    assign zero   = out_valid ? head.zero : 1'b0;
    assign neg    = out_valid ? head.neg : 1'b0;

endmodule

// File: tb/tb_move_unit.sv
// Directed self-checking bench for move_unit: an 8-bit/2-deep instance and a
// 16-bit/3-deep instance driven through hand-computed vectors.
module tb_move_unit;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, neg8;
    logic [1:0]  op8;
    logic [7:0]  a8, a_move8;
    logic [1:0]  count8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16, neg16;
    logic [1:0]  op16;
    logic [15:0] a16, a_move16;
    logic [1:0]  count16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    move_unit #(.WIDTH(8), .DEPTH(2)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .A(a8), .out_valid(out_valid8), .out_ready(out_ready8),
        .A_move(a_move8), .zero(zero8), .neg(neg8), .count(count8)
    );

    move_unit #(.WIDTH(16), .DEPTH(3)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .A(a16), .out_valid(out_valid16), .out_ready(out_ready16),
        .A_move(a_move16), .zero(zero16), .neg(neg16), .count(count16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [1:0] o,
                                 input logic [7:0] a, input logic ordy);
        in_valid8  = iv;
        op8        = o;
        a8         = a;
        out_ready8 = ordy;
    endtask

    task automatic applyStimulus16(input logic iv, input logic [1:0] o,
                                   input logic [15:0] a, input logic ordy);
        in_valid16  = iv;
        op16        = o;
        a16         = a;
        out_ready16 = ordy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks the full visible state of the 8-bit instance in one call.
    task automatic check8(input string tag, input logic ov, input logic [7:0] am,
                          input logic z, input logic n, input logic [1:0] c,
                          input logic ir);
        checkOutput({tag, ".out_valid"}, 32'(out_valid8), 32'(ov));
        checkOutput({tag, ".A_move"},    32'(a_move8),    32'(am));
        checkOutput({tag, ".zero"},      32'(zero8),      32'(z));
        checkOutput({tag, ".neg"},       32'(neg8),       32'(n));
        checkOutput({tag, ".count"},     32'(count8),     32'(c));
        checkOutput({tag, ".in_ready"},  32'(in_ready8),  32'(ir));
    endtask

    task automatic check16(input string tag, input logic ov, input logic [15:0] am,
                           input logic [1:0] c, input logic ir);
        checkOutput({tag, ".out_valid"}, 32'(out_valid16), 32'(ov));
        checkOutput({tag, ".A_move"},    32'(a_move16),    32'(am));
        checkOutput({tag, ".count"},     32'(count16),     32'(c));
        checkOutput({tag, ".in_ready"},  32'(in_ready16),  32'(ir));
        checkOutput({tag, ".count_le3"}, 32'(count16 <= 2'd3), 32'(1));
    endtask

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 8'h00, 1'b0);
        applyStimulus16(1'b0, 2'b00, 16'h0000, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check8("reset", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
        check16("reset16", 1'b0, 16'h0000, 2'd0, 1'b1);

        // Latency: one-cycle push-to-visible, then drained
        applyStimulus(1'b1, 2'b00, 8'hA5, 1'b1);
        tick();
        check8("lat_mov", 1'b1, 8'hA5, 1'b0, 1'b1, 2'd1, 1'b1);
        applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
        tick();
        check8("lat_empty", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);

        // Opcodes back-to-back
        applyStimulus(1'b1, 2'b01, 8'h0F, 1'b1);
        tick();
        check8("op_mvn", 1'b1, 8'hF0, 1'b0, 1'b1, 2'd1, 1'b1);
        applyStimulus(1'b1, 2'b10, 8'h77, 1'b1);
        tick();
        check8("op_clr", 1'b1, 8'h00, 1'b1, 1'b0, 2'd1, 1'b1);
        applyStimulus(1'b1, 2'b11, 8'h3C, 1'b1);
        tick();
        check8("op_swp", 1'b1, 8'hC3, 1'b0, 1'b1, 2'd1, 1'b1);
        applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
        tick();
        check8("op_drain", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);

        // Pop on empty must not underflow
        tick();
        check8("empty_pop", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);

        // Full and ordering
        applyStimulus(1'b1, 2'b00, 8'h01, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b00, 8'h02, 1'b0);
        tick();
        check8("full", 1'b1, 8'h01, 1'b0, 1'b0, 2'd2, 1'b0);
        applyStimulus(1'b1, 2'b00, 8'h03, 1'b0);
        tick();
        check8("full_drop", 1'b1, 8'h01, 1'b0, 1'b0, 2'd2, 1'b0);
        applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
        tick();
        check8("pop1", 1'b1, 8'h02, 1'b0, 1'b0, 2'd1, 1'b1);
        tick();
        check8("pop2", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);

        // Simultaneous push and pop
        applyStimulus(1'b1, 2'b00, 8'h11, 1'b0);
        tick();
        check8("sim_pre", 1'b1, 8'h11, 1'b0, 1'b0, 2'd1, 1'b1);
        applyStimulus(1'b0, 2'b00, 8'h00, 1'b0);
        tick();
        check8("stall_hold", 1'b1, 8'h11, 1'b0, 1'b0, 2'd1, 1'b1);
        applyStimulus(1'b1, 2'b00, 8'h22, 1'b1);
        tick();
        check8("sim_pushpop", 1'b1, 8'h22, 1'b0, 1'b0, 2'd1, 1'b1);
        applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
        tick();
        check8("sim_drain", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);

        // Reset mid-operation discards contents and ignores the reset-cycle input
        applyStimulus(1'b1, 2'b00, 8'hAA, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b00, 8'hBB, 1'b0);
        tick();
        check8("rst_pre", 1'b1, 8'hAA, 1'b0, 1'b1, 2'd2, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 2'b00, 8'hCC, 1'b0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 2'b00, 8'h00, 1'b0);
        check8("rst_mid", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
        tick();
        check8("rst_after", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);

        // WIDTH=16, DEPTH=3 with pointer wrap
        applyStimulus16(1'b1, 2'b11, 16'h12FF, 1'b0);
        tick();
        check16("w16_swp", 1'b1, 16'hFF12, 2'd1, 1'b1);
        checkOutput("w16_swp.neg",  32'(neg16),  32'(1));
        checkOutput("w16_swp.zero", 32'(zero16), 32'(0));
        applyStimulus16(1'b1, 2'b00, 16'h0001, 1'b0);
        tick();
        applyStimulus16(1'b1, 2'b00, 16'h0002, 1'b0);
        tick();
        check16("w16_full", 1'b1, 16'hFF12, 2'd3, 1'b0);
        applyStimulus16(1'b1, 2'b00, 16'h0003, 1'b0);
        tick();
        check16("w16_drop", 1'b1, 16'hFF12, 2'd3, 1'b0);
        applyStimulus16(1'b0, 2'b00, 16'h0000, 1'b1);
        tick();
        check16("w16_pop1", 1'b1, 16'h0001, 2'd2, 1'b1);
        applyStimulus16(1'b1, 2'b00, 16'h0004, 1'b1);
        tick();
        check16("w16_wrap", 1'b1, 16'h0002, 2'd2, 1'b1);
        applyStimulus16(1'b0, 2'b00, 16'h0000, 1'b1);
        tick();
        check16("w16_pop3", 1'b1, 16'h0004, 2'd1, 1'b1);
        tick();
        check16("w16_empty", 1'b0, 16'h0000, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
